// File: rtl/adder_rr_arbiter.sv
// Round-robin front end that shares one pipelined adder between two requesters.
// A tag pipeline that tracks each operation's owner routes each registered result back to that owner.
module adder_rr_arbiter #(
    parameter int WIDTH = 4,
    parameter int LAT   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             req1_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    output logic             rsp0_valid,
    output logic [WIDTH:0]   rsp0_sum,
    output logic             rsp1_valid,
    output logic [WIDTH:0]   rsp1_sum,
    output logic             busy
);

    logic         ptr;
    logic         grant0;
    logic         grant1;
    logic         xfer;
    logic         win_id;
    logic [LAT:0] tag_valid;
    logic [LAT:0] tag_id;

    // ptr names the requester that wins when both requesters are valid.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | ~ptr);
        grant1 = req1_valid & (~req0_valid | ptr);
    end

    assign req0_ready = rst & grant0;
    assign req1_ready = rst & grant1;
    assign xfer       = req0_ready | req1_ready;
    assign win_id     = req1_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (xfer) begin
            ptr <= ~win_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
        end else if (xfer) begin
            add_a   <= win_id ? req1_a   : req0_a;
            add_b   <= win_id ? req1_b   : req0_b;
            add_cin <= win_id ? req1_cin : req0_cin;
        end else begin
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
        end
    end

    // The top stage lines up with the adder output for the operation issued LAT edges earlier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            tag_valid <= {tag_valid[LAT-1:0], xfer};
            tag_id    <= {tag_id[LAT-1:0], win_id};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_sum   <= '0;
            rsp1_sum   <= '0;
        end else begin
            rsp0_valid <= tag_valid[LAT] & ~tag_id[LAT];
            rsp1_valid <= tag_valid[LAT] & tag_id[LAT];
            if (tag_valid[LAT] && !tag_id[LAT]) begin
                rsp0_sum <= {add_cout, add_s};
            end
            if (tag_valid[LAT] && tag_id[LAT]) begin
                rsp1_sum <= {add_cout, add_s};
            end
        end
    end

    // busy stays high through the result strobe cycle and drops on the cycle after it.
    assign busy = (|tag_valid) | rsp0_valid | rsp1_valid;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Testbench for adder_rr_arbiter: two instances (LAT=4 and LAT=1) share one set of requests and
// are compared against a queue-based reference model and a behavioural adder model for each.
module tb_adder_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic req0_valid, req0_cin, req1_valid, req1_cin;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;

    logic rdy0_4, rdy1_4, ac4, co4, r0v4, r1v4, busy4;
    logic [3:0] aa4, ab4, s4;
    logic [4:0] r0s4, r1s4;
    logic rdy0_1, rdy1_1, ac1, co1, r0v1, r1v1, busy1;
    logic [3:0] aa1, ab1, s1;
    logic [4:0] r0s1, r1s1;

    logic [4:0] pipe4 [4];
    logic [4:0] pipe1;

    typedef struct {
        int         due;
        logic       id;
        logic [4:0] sum;
    } exp_t;

    exp_t       q4[$];
    exp_t       q1[$];
    int         cyc;
    logic       prio;
    logic       exp_rdy0, exp_rdy1;
    logic [4:0] last4 [2];
    logic [4:0] last1 [2];
    logic [21:0] expv4, expv1;
    int         n_checks = 0;
    int         n_errors = 0;

    wire [21:0] act4 = {r0v4, r1v4, r0s4, r1s4, busy4, aa4, ab4, ac4};
    wire [21:0] act1 = {r0v1, r1v1, r0s1, r1s1, busy1, aa1, ab1, ac1};

    always #5 clk = ~clk;

    adder_rr_arbiter #(.WIDTH(4), .LAT(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req0_ready(rdy0_4),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .req1_ready(rdy1_4),
        .add_a(aa4), .add_b(ab4), .add_cin(ac4), .add_s(s4), .add_cout(co4),
        .rsp0_valid(r0v4), .rsp0_sum(r0s4), .rsp1_valid(r1v4), .rsp1_sum(r1s4),
        .busy(busy4)
    );

    adder_rr_arbiter #(.WIDTH(4), .LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req0_ready(rdy0_1),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .req1_ready(rdy1_1),
        .add_a(aa1), .add_b(ab1), .add_cin(ac1), .add_s(s1), .add_cout(co1),
        .rsp0_valid(r0v1), .rsp0_sum(r0s1), .rsp1_valid(r1v1), .rsp1_sum(r1s1),
        .busy(busy1)
    );

    // Behavioural pipelined adders: the result is visible LAT edges after the operands change.
    always @(posedge clk) begin
        pipe4[0] <= 5'(aa4) + 5'(ab4) + 5'(ac4);
        for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
        pipe1 <= 5'(aa1) + 5'(ab1) + 5'(ac1);
    end
    assign {co4, s4} = pipe4[3];
    assign {co1, s1} = pipe1;

    task automatic model_reset();
        q4.delete();
        q1.delete();
        prio = 1'b0;
        last4[0] = '0; last4[1] = '0;
        last1[0] = '0; last1[1] = '0;
        expv4 = '0;
        expv1 = '0;
    endtask

    task automatic set_req(input logic v0, input logic [3:0] a0, input logic [3:0] b0, input logic c0,
                           input logic v1, input logic [3:0] a1, input logic [3:0] b1, input logic c1);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
        #2;
        exp_rdy0 = rst && v0 && (!v1 || prio == 1'b0);
        exp_rdy1 = rst && v1 && (!v0 || prio == 1'b1);
    endtask

    task automatic idle();
        set_req(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    // Advances one edge and updates the model: issued ops become due LAT+1 edges later.
    task automatic tick();
        exp_t e;
        logic [3:0] oa, ob;
        logic oc, v0, v1;
        oa = '0; ob = '0; oc = 1'b0;
        if (rst && (exp_rdy0 || exp_rdy1)) begin
            oa = exp_rdy1 ? req1_a : req0_a;
            ob = exp_rdy1 ? req1_b : req0_b;
            oc = exp_rdy1 ? req1_cin : req0_cin;
            e.id = exp_rdy1;
            e.sum = 5'(oa) + 5'(ob) + 5'(oc);
            e.due = cyc + 1 + 5;
            q4.push_back(e);
            e.due = cyc + 1 + 2;
            q1.push_back(e);
            prio = exp_rdy0;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (!rst) begin
            model_reset();
        end else begin
            v0 = 1'b0; v1 = 1'b0;
            if (q4.size() > 0 && q4[0].due == cyc) begin
                e = q4.pop_front();
                last4[e.id] = e.sum;
                if (e.id) v1 = 1'b1; else v0 = 1'b1;
            end
            expv4 = {v0, v1, last4[0], last4[1], (q4.size() > 0) || v0 || v1, oa, ob, oc};
            v0 = 1'b0; v1 = 1'b0;
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e = q1.pop_front();
                last1[e.id] = e.sum;
                if (e.id) v1 = 1'b1; else v0 = 1'b1;
            end
            expv1 = {v0, v1, last1[0], last1[1], (q1.size() > 0) || v0 || v1, oa, ob, oc};
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        set_req(1'b1, 4'h3, 4'h4, 1'b0, 1'b1, 4'h5, 4'h6, 1'b1);
        n_checks++;
        if ({rdy0_4, rdy1_4} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_ready got %b want 00", {rdy0_4, rdy1_4});
        end
        n_checks++;
        if (act4 !== 22'h0) begin
            n_errors++;
            $display("FAIL reset_outputs got %h want 0", act4);
        end
        tick();
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 4'h0, 4'h0, 1'b0);
            n_checks++;
            if (rdy0_4 !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_prefill_ready got %b want 1", rdy0_4);
            end
            tick();
        end
        set_req(1'b1, 4'h7, 4'h7, 1'b1, 1'b1, 4'h2, 4'h2, 1'b0);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({act4, rdy0_4, rdy1_4} !== 24'h0) begin
            n_errors++;
            $display("FAIL reset_async got %h want 0", {act4, rdy0_4, rdy1_4});
        end
        model_reset();
        for (int i = 0; i < 2; i++) begin
            set_req(1'b1, 4'h7, 4'h7, 1'b1, 1'b1, 4'h2, 4'h2, 1'b0);
            n_checks++;
            if ({rdy0_4, rdy1_4} !== 2'b00) begin
                n_errors++;
                $display("FAIL reset_held_ready got %b want 00", {rdy0_4, rdy1_4});
            end
            tick();
        end
        #2 rst = 1'b1;
        for (int i = 0; i < 7; i++) begin
            idle();
            tick();
            n_checks++;
            if ({act4, r0v1, r1v1, busy1} !== 25'h0) begin
                n_errors++;
                $display("FAIL reset_no_strobe cycle %0d got %h want 0", i, {act4, r0v1, r1v1, busy1});
            end
        end
        set_req(1'b1, 4'h1, 4'h2, 1'b0, 1'b1, 4'h3, 4'h4, 1'b0);
        n_checks++;
        if ({rdy0_4, rdy1_4} !== 2'b10) begin
            n_errors++;
            $display("FAIL reset_first_grant got %b want 10", {rdy0_4, rdy1_4});
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            idle();
            tick();
        end
    endtask

    task automatic test_single();
        int found = -1;
        int pulses = 0;
        int saw1 = 0;
        logic [4:0] got = '0;
        set_req(1'b1, 4'h9, 4'h8, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        n_checks++;
        if (rdy0_4 !== 1'b1) begin
            n_errors++;
            $display("FAIL single_ready got %b want 1", rdy0_4);
        end
        tick();
        for (int i = 1; i <= 8; i++) begin
            idle();
            tick();
            if (r0v4) begin
                pulses++;
                if (found < 0) begin
                    found = i;
                    got = r0s4;
                end
            end
            if (r1v4) saw1++;
        end
        n_checks++;
        if (found != 5 || pulses != 1) begin
            n_errors++;
            $display("FAIL single_latency got %0d (pulses %0d) want 5 (pulses 1)", found, pulses);
        end
        n_checks++;
        if (got !== 5'h12) begin
            n_errors++;
            $display("FAIL single_sum got %h want 12", got);
        end
        n_checks++;
        if (saw1 != 0) begin
            n_errors++;
            $display("FAIL single_other_quiet got %0d strobes want 0", saw1);
        end
    endtask

    task automatic test_contention();
        logic [5:0] pat = '0;
        int cnt = 0;
        int first_t = -1;
        int last_t = -1;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            if (i < 6) begin
                set_req(1'b1, 4'($urandom), 4'($urandom), 1'($urandom),
                        1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
                n_checks++;
                if ({rdy0_4, rdy1_4} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_errors++;
                    $display("FAIL contention_grant %0d got %b want %b", i, {rdy0_4, rdy1_4},
                             (i % 2 == 0) ? 2'b10 : 2'b01);
                end
            end else begin
                idle();
            end
            tick();
            n_checks++;
            if (act4 !== expv4) begin
                n_errors++;
                $display("FAIL contention_model cycle %0d got %h want %h", i, act4, expv4);
            end
            if (r0v4 || r1v4) begin
                if (cnt < 6) pat[cnt] = r1v4;
                if (first_t < 0) first_t = i;
                last_t = i;
                cnt++;
            end
        end
        n_checks++;
        if (cnt != 6 || pat !== 6'b101010 || (last_t - first_t) != 5) begin
            n_errors++;
            $display("FAIL contention_order got cnt %0d pat %b span %0d want 6 101010 5",
                     cnt, pat, last_t - first_t);
        end
    endtask

    task automatic test_boundary();
        logic [4:0] got [2];
        int cnt = 0;
        int saw0 = 0;
        set_req(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b1);
        n_checks++;
        if (rdy1_4 !== 1'b1) begin
            n_errors++;
            $display("FAIL boundary_ready_max got %b want 1", rdy1_4);
        end
        tick();
        set_req(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        n_checks++;
        if (rdy1_4 !== 1'b1) begin
            n_errors++;
            $display("FAIL boundary_ready_zero got %b want 1", rdy1_4);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            idle();
            tick();
            if (r1v4) begin
                if (cnt < 2) got[cnt] = r1s4;
                cnt++;
            end
            if (r0v4) saw0++;
        end
        n_checks++;
        if (cnt != 2 || got[0] !== 5'h1F || got[1] !== 5'h00 || saw0 != 0) begin
            n_errors++;
            $display("FAIL boundary_sums got cnt %0d %h %h rsp0 %0d want 2 1f 00 0",
                     cnt, got[0], got[1], saw0);
        end
    endtask

    task automatic test_gap();
        for (int k = 0; k <= 12; k++) begin
            if (k == 0) set_req(1'b1, 4'h2, 4'h3, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
            else if (k == 4) set_req(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h6, 4'h1, 1'b1);
            else idle();
            tick();
            n_checks++;
            if (busy4 !== (k <= 9)) begin
                n_errors++;
                $display("FAIL gap_busy k %0d got %b want %b", k, busy4, (k <= 9));
            end
            n_checks++;
            if (act4 !== expv4) begin
                n_errors++;
                $display("FAIL gap_model k %0d got %h want %h", k, act4, expv4);
            end
        end
        set_req(1'b1, 4'h1, 4'h1, 1'b0, 1'b1, 4'h1, 4'h1, 1'b0);
        n_checks++;
        if ({rdy0_4, rdy1_4} !== 2'b10) begin
            n_errors++;
            $display("FAIL gap_pointer got %b want 10", {rdy0_4, rdy1_4});
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            idle();
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1010; i++) begin
            if (i < 1000) begin
                set_req($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 1'($urandom),
                        $urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 1'($urandom));
            end else begin
                idle();
            end
            n_checks++;
            if ({rdy0_4, rdy1_4, rdy0_1, rdy1_1} !== {exp_rdy0, exp_rdy1, exp_rdy0, exp_rdy1}) begin
                n_errors++;
                $display("FAIL rand_ready cycle %0d got %b want %b", i,
                         {rdy0_4, rdy1_4, rdy0_1, rdy1_1}, {exp_rdy0, exp_rdy1, exp_rdy0, exp_rdy1});
            end
            tick();
            n_checks++;
            if (act4 !== expv4) begin
                n_errors++;
                $display("FAIL rand_lat4 cycle %0d got %h want %h", i, act4, expv4);
            end
            n_checks++;
            if (act1 !== expv1) begin
                n_errors++;
                $display("FAIL rand_lat1 cycle %0d got %h want %h", i, act1, expv1);
            end
        end
        n_checks++;
        if (q4.size() != 0 || q1.size() != 0) begin
            n_errors++;
            $display("FAIL rand_drain got %0d/%0d pending want 0/0", q4.size(), q1.size());
        end
    endtask

    initial begin
        rst = 1'b0;
        cyc = 0;
        exp_rdy0 = 1'b0;
        exp_rdy1 = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_contention();
        test_boundary();
        test_gap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one pipelined WIDTH-bit adder (fixed latency LAT) between two requesters.
- Each requester presents operands with a valid/ready handshake.
- Round-robin arbitration issues at most one operation per cycle into the adder.
- A tag pipeline tracks which requester owns each in-flight operation and routes each registered sum/carry result back to that owner.
- Sits between the operand sources and the pipelined ripple adder, and drives the adder's operand and carry inputs.

Parameters:
- WIDTH, 4, operand width of the shared adder.
- LAT, 4, adder latency: edges from operand change at adder inputs to valid add_s/add_cout. Must be ≥1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_cin  in  1  requester 0 carry-in.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req1_valid  in  1  requester 1 has an operation pending.
- req1_a  in  WIDTH  requester 1 operand A.
- req1_b  in  WIDTH  requester 1 operand B.
- req1_cin  in  1  requester 1 carry-in.
- req1_ready  out  1  requester 1 operation accepted this cycle.
- add_a  out  WIDTH  registered operand A to the adder.
- add_b  out  WIDTH  registered operand B to the adder.
- add_cin  out  1  registered carry-in to the adder.
- add_s  in  WIDTH  sum from the adder.
- add_cout  in  1  carry-out from the adder.
- rsp0_valid  out  1  one-cycle result strobe for requester 0.
- rsp0_sum  out  WIDTH+1  {cout, sum} result for requester 0.
- rsp1_valid  out  1  one-cycle result strobe for requester 1.
- rsp1_sum  out  WIDTH+1  {cout, sum} result for requester 1.
- busy  out  1  at least one operation in flight.

Behaviour:
- **Reset (rst=0, asynchronous):** all of the following clear immediately:
  - add_a, add_b, add_cin → 0
  - rsp0/1_valid → 0; rsp0/1_sum → 0
  - tag pipeline → empty; busy → 0
  - priority pointer → requester 0
  - reqN_ready is forced to 0 while rst=0.
- **Arbitration (combinational, every cycle):**
  - Only one valid: that requester wins.
  - Both valid: the requester indicated by the priority pointer wins.
  - reqN_ready = 1 only for the winner; at most one ready per cycle.
  - No valid: neither ready.
- **Pointer update:** on an edge with a transfer, the pointer moves to the requester that was not granted. With no transfer, the pointer holds.
- **Issue:**
  - Transfer = valid & ready at edge E0.
  - At E0, add_a/add_b/add_cin register the winner's operands.
  - Idle cycles register 0 on add_a/add_b/add_cin.
  - Throughput: one operation per cycle, no bubbles.
- **Tag pipeline:** LAT+1 stages of {valid, id}.
  - Stage 0 loads {transfer, winner id} at E0.
  - All stages shift every edge.
- **Result capture:** the stage holding the E0 entry after edge E0+LAT gates a registered capture at edge E0+LAT+1:
  - rsp<id>_sum ← {add_cout, add_s}
  - rsp<id>_valid = 1 for exactly one cycle.
  - The other requester's rsp_valid = 0 that cycle.
  - rspN_sum holds its last value when not valid.
- **Latency:** LAT+1 cycles, handshake edge to rsp_valid.
- **Ordering:** results return in issue order. Back-to-back results may alternate between or repeat the same requester.
- **Backpressure:** results have none; consumers must accept every strobe.
- **busy:** = OR of all tag valid bits, including the capture stage. It deasserts the cycle after the last rsp strobe.
- **Reset mid-operation:** in-flight tags are discarded, no rsp strobe is produced for them, and the pointer returns to requester 0.
- **Width rules:**
  - rspN_sum[WIDTH] = add_cout; rspN_sum[WIDTH-1:0] = add_s.
  - No overflow flag; the full result is the unsigned sum A+B+cin, range 0..2^(WIDTH+1)-1.
- **Operand stability:** operands are sampled only at the transfer edge. A requester may change its operands freely while not ready.

Test Plan:
- **Reset:** rst=0 held mid-stream with 3 ops in flight, then released → all outputs 0, busy=0, no rsp strobes afterwards; next contention grants req0 first.
- **Single requester:** req0_valid=1 with a=4'h9, b=4'h8, cin=1 for one transfer → rsp0_valid pulses exactly 5 cycles later with rsp0_sum=5'h12; rsp1_valid stays 0.
- **Contention:** both valid continuously for 6 cycles → grants alternate 0,1,0,1,0,1 starting with req0; rsp strobes alternate in the same order, one per cycle.
- **Boundary values:** req1 a=4'hF, b=4'hF, cin=1 → rsp1_sum=5'h1F. Then a=0, b=0, cin=0 → 5'h00.
- **Gap behaviour:** req0 transfers, 3 idle cycles, req1 transfers → busy stays high from the first transfer until the cycle after rsp1_valid; the pointer points to req0 after the req1 grant.
- **Self-check:** random valids and operands for 1000 cycles → a scoreboard confirms every result matches A+B+cin with the correct owner, in order, and the adder model is exercised at LAT=4 and LAT=1.
